// File: rtl/complex_fir_coeff_loader_pkg.sv
// complex_fir_coeff_loader_pkg -- shared widths, limits and FSM encoding for the coefficient loader.
// Revision: 1.0
`default_nettype none

package complex_fir_coeff_loader_pkg;

  localparam int COEFF_WIDTH = 18;
  localparam int MAX_TAPS    = 1023;
  localparam int CNT_WIDTH   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Smallest address width able to index a store of the given depth (never zero).
  function automatic int addr_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/complex_coeff_ram.sv
// complex_coeff_ram -- dual Re/Im coefficient arrays, synchronous write, registered read.
// Revision: 1.0
`default_nettype none

module complex_coeff_ram #(
  parameter int LENGTH     = 20,
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_re_i,
  input  logic [DATA_WIDTH-1:0] wr_im_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_re_o,
  output logic [DATA_WIDTH-1:0] rd_im_o
);

  logic [DATA_WIDTH-1:0] mem_re_q [0:LENGTH-1];
  logic [DATA_WIDTH-1:0] mem_im_q [0:LENGTH-1];
  logic [DATA_WIDTH-1:0] rd_re_q;
  logic [DATA_WIDTH-1:0] rd_im_q;

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_re_q[wr_addr_i] <= wr_re_i;
      mem_im_q[wr_addr_i] <= wr_im_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_re_q <= mem_re_q[rd_addr_i];
      rd_im_q <= mem_im_q[rd_addr_i];
    end
  end

  assign rd_re_o = rd_re_q;
  assign rd_im_o = rd_im_q;

endmodule

`default_nettype wire

// File: rtl/complex_fir_coeff_loader.sv
// complex_fir_coeff_loader -- owns the complex FIR coefficient store and streams it into the filter.
// Revision: 1.0
`default_nettype none

module complex_fir_coeff_loader
  import complex_fir_coeff_loader_pkg::*;
#(
  parameter int LENGTH     = 20,
  parameter int DATA_WIDTH = COEFF_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  hostWrEn,
  input  logic [CNT_WIDTH-1:0]  hostAddr,
  input  logic [DATA_WIDTH-1:0] hostCoeffRe,
  input  logic [DATA_WIDTH-1:0] hostCoeffIm,
  output logic                  hostWrReject,
  input  logic                  loadReq,
  output logic                  loadBusy,
  output logic                  coeffValid,
  output logic [DATA_WIDTH-1:0] coeffOutRe,
  output logic [DATA_WIDTH-1:0] coeffOutIm,
  output logic                  coeffSetFlag,
  output logic                  filterEnable
);

  localparam int                   ADDR_W   = addr_width(LENGTH);
  localparam logic [CNT_WIDTH-1:0] LAST_TAP = CNT_WIDTH'(LENGTH - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic                 reject_q, reject_d;
  logic                 wr_accept;
  logic                 rd_en;
  logic [DATA_WIDTH-1:0] rd_re;
  logic [DATA_WIDTH-1:0] rd_im;

  assign wr_accept = hostWrEn && (state_q != LOAD) && (hostAddr <= LAST_TAP);
  assign reject_d  = hostWrEn && !wr_accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      reject_q <= reject_d;
    end
  end

  // done_q marks that the last address has been issued; LOAD lingers one more
  // cycle so the final registered read beat leaves before RUN is entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    valid_d = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (loadReq) begin
          state_d = LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      LOAD: begin
        if (done_q) begin
          state_d = RUN;
        end else begin
          rd_en   = 1'b1;
          valid_d = 1'b1;
          if (cnt_q == LAST_TAP) begin
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  complex_coeff_ram #(
    .LENGTH     (LENGTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk_i     (clock),
    .wr_en_i   (wr_accept),
    .wr_addr_i (hostAddr[ADDR_W-1:0]),
    .wr_re_i   (hostCoeffRe),
    .wr_im_i   (hostCoeffIm),
    .rd_en_i   (rd_en),
    .rd_addr_i (cnt_q[ADDR_W-1:0]),
    .rd_re_o   (rd_re),
    .rd_im_o   (rd_im)
  );

  assign loadBusy     = (state_q == LOAD);
  assign coeffSetFlag = (state_q == RUN);
  assign filterEnable = (state_q == RUN);
  assign coeffValid   = valid_q;
  assign hostWrReject = reject_q;
  assign coeffOutRe   = valid_q ? rd_re : '0;
  assign coeffOutIm   = valid_q ? rd_im : '0;

endmodule

`default_nettype wire

// File: tb/tb_complex_fir_coeff_loader.sv
// tb_complex_fir_coeff_loader -- directed stimulus, cycle-level reference model and literal beat checks.
// Revision: 1.0
`default_nettype none

module tb_complex_fir_coeff_loader;

  localparam int L  = 20;
  localparam int DW = 18;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          hostWrEn;
  logic [9:0]    hostAddr;
  logic [DW-1:0] hostCoeffRe;
  logic [DW-1:0] hostCoeffIm;
  logic          hostWrReject;
  logic          loadReq;
  logic          loadBusy;
  logic          coeffValid;
  logic [DW-1:0] coeffOutRe;
  logic [DW-1:0] coeffOutIm;
  logic          coeffSetFlag;
  logic          filterEnable;

  int n_checks = 0;
  int n_errors = 0;

  complex_fir_coeff_loader #(.LENGTH(L), .DATA_WIDTH(DW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .hostWrEn     (hostWrEn),
    .hostAddr     (hostAddr),
    .hostCoeffRe  (hostCoeffRe),
    .hostCoeffIm  (hostCoeffIm),
    .hostWrReject (hostWrReject),
    .loadReq      (loadReq),
    .loadBusy     (loadBusy),
    .coeffValid   (coeffValid),
    .coeffOutRe   (coeffOutRe),
    .coeffOutIm   (coeffOutIm),
    .coeffSetFlag (coeffSetFlag),
    .filterEnable (filterEnable)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] beat(input int re, input int im);
    logic [31:0] r;
    logic [31:0] i;
    r = re;
    i = im;
    return {r[17:0], i[17:0]};
  endfunction

  // Reference model: timeline of the most recent accepted load request (cycle ld_n)
  // and a snapshot of the coefficient store taken at that moment.
  logic [DW-1:0] m_re [L];
  logic [DW-1:0] m_im [L];
  logic [DW-1:0] s_re [L];
  logic [DW-1:0] s_im [L];
  int   cyc = 0;
  int   ld_n = 0;
  bit   have_load = 0;
  bit   busy_now;
  int   t;
  logic          exp_busy = 0, exp_valid = 0, exp_set = 0, exp_rej = 0;
  logic [DW-1:0] exp_re = '0, exp_im = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      have_load = 0;
      exp_busy  = 0;
      exp_valid = 0;
      exp_set   = 0;
      exp_rej   = 0;
      exp_re    = '0;
      exp_im    = '0;
    end else begin
      busy_now = have_load && (cyc >= ld_n + 1) && (cyc <= ld_n + L + 1);
      exp_rej  = hostWrEn && (busy_now || (int'(hostAddr) >= L));
      if (hostWrEn && !exp_rej) begin
        m_re[hostAddr] = hostCoeffRe;
        m_im[hostAddr] = hostCoeffIm;
      end
      if (loadReq && !busy_now) begin
        ld_n      = cyc;
        have_load = 1;
        s_re      = m_re;
        s_im      = m_im;
      end
      t         = cyc + 1;
      exp_busy  = have_load && (t >= ld_n + 1) && (t <= ld_n + L + 1);
      exp_valid = have_load && (t >= ld_n + 2) && (t <= ld_n + L + 1);
      exp_set   = have_load && (t >= ld_n + L + 2);
      exp_re    = exp_valid ? s_re[t - ld_n - 2] : '0;
      exp_im    = exp_valid ? s_im[t - ld_n - 2] : '0;
      cyc++;
    end
  end

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      chk("cycle_outputs",
          {22'd0, loadBusy, coeffValid, coeffOutRe, coeffOutIm, coeffSetFlag, filterEnable, hostWrReject},
          {22'd0, exp_busy, exp_valid, exp_re, exp_im, exp_set, exp_set, exp_rej});
    end
  end

  logic [35:0] beats [$];
  always @(negedge clock) begin
    if (reset_n === 1'b1 && coeffValid === 1'b1) beats.push_back({coeffOutRe, coeffOutIm});
  end

  task automatic write_tap(input int addr, input int re, input int im);
    hostWrEn    = 1'b1;
    hostAddr    = 10'(addr);
    hostCoeffRe = DW'(re);
    hostCoeffIm = DW'(im);
    @(negedge clock);
    hostWrEn    = 1'b0;
  endtask

  task automatic pulse_load();
    beats.delete();
    loadReq = 1'b1;
    @(negedge clock);
    loadReq = 1'b0;
  endtask

  task automatic wait_set(input string name);
    for (int i = 0; i < 60 && coeffSetFlag !== 1'b1; i++) @(negedge clock);
    chk(name, 64'(coeffSetFlag), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0; hostWrEn = 1'b0; hostAddr = '0;
    hostCoeffRe = '0; hostCoeffIm = '0; loadReq = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outputs",
        {22'd0, loadBusy, coeffValid, coeffOutRe, coeffOutIm, coeffSetFlag, filterEnable, hostWrReject}, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    write_tap(20, 5, 5);
    chk("reject_addr20", 64'(hostWrReject), 64'd1);

    for (int k = 0; k < L; k++) write_tap(k, k * 100, -k);
    pulse_load();
    chk("busy_at_n1", {62'd0, loadBusy, coeffValid}, 64'b10);
    wait_set("first_load_done");
    chk("first_beat_count", 64'(beats.size()), 64'd20);
    chk("first_beat1", 64'(beats[1]), 64'(beat(100, -1)));
    chk("first_beat19", 64'(beats[19]), 64'(beat(1900, -19)));

    pulse_load();
    repeat (3) @(negedge clock);
    write_tap(3, 999, 999);
    chk("reject_during_load", 64'(hostWrReject), 64'd1);
    wait_set("second_load_done");

    write_tap(0, 131071, -131072);
    pulse_load();
    chk("enable_drop", {62'd0, coeffSetFlag, filterEnable}, 64'd0);
    wait_set("reload_done");
    chk("reload_beat0", 64'(beats[0]), 64'(beat(131071, -131072)));
    chk("tap3_unchanged", 64'(beats[3]), 64'(beat(300, -3)));

    write_tap(1, -131072, 131071);
    write_tap(2, 131071, -131072);
    pulse_load();
    wait_set("extreme_load_done");
    chk("extreme_beat1", 64'(beats[1]), 64'(beat(-131072, 131071)));
    chk("extreme_beat2", 64'(beats[2]), 64'(beat(131071, -131072)));

    pulse_load();
    for (int i = 0; i < 30 && beats.size() < 7; i++) @(negedge clock);
    chk("reached_beat7", 64'(beats.size() >= 7), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {22'd0, loadBusy, coeffValid, coeffOutRe, coeffOutIm, coeffSetFlag, filterEnable, hostWrReject}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("idle_after_reset", {61'd0, loadBusy, coeffValid, filterEnable}, 64'd0);

    beats.delete();
    hostWrEn = 1'b1; hostAddr = 10'd5; hostCoeffRe = DW'(42); hostCoeffIm = DW'(7);
    loadReq  = 1'b1;
    @(negedge clock);
    hostWrEn = 1'b0;
    loadReq  = 1'b0;
    wait_set("simul_load_done");
    chk("simul_beat_count", 64'(beats.size()), 64'd20);
    chk("simul_beat5", 64'(beats[5]), 64'(beat(42, 7)));

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
